// File: rtl/dz_scan_ctrl.sv
// Double-buffered red/green dot-matrix scan driver with row dwell, anti-ghost
// blanking, blink masking and a tear-free front/back swap at the frame boundary.
module dz_scan_ctrl #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int DWELL          = 125,
  parameter int BLANK          = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter int ROW_ACTIVE_LOW = 1,
  localparam int RW            = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_r,
  input  logic [COLS-1:0] wr_g,
  input  logic            swap,
  input  logic            blink,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] colr,
  output logic [COLS-1:0] colg,
  output logic            swap_busy,
  output logic            frame_done
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int FW = $clog2(2 * BLINK_FRAMES);
  localparam logic [ROWS-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

  logic [DW-1:0]   dwell_q, dwell_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            front_q, front_d;
  logic            pending_q, pending_d;
  logic [COLS-1:0] buf_r_q [2][ROWS];
  logic [COLS-1:0] buf_r_d [2][ROWS];
  logic [COLS-1:0] buf_g_q [2][ROWS];
  logic [COLS-1:0] buf_g_d [2][ROWS];
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] colr_q, colr_d;
  logic [COLS-1:0] colg_q, colg_d;
  logic            frame_done_q, frame_done_d;

  logic            dwell_last;
  logic            last_slot;
  logic            commit;
  logic            in_blank;
  logic            blink_dark;
  logic            wr_ok;
  logic [ROWS-1:0] row_sel;
  logic [ROWS-1:0] row_on;

  // Row indices that the port width can express but the matrix lacks are dropped.
  if (ROWS == (1 << RW)) begin : g_wr_full
    assign wr_ok = 1'b1;
  end else begin : g_wr_chk
    assign wr_ok = (wr_row < RW'(ROWS));
  end

  always_comb begin
    dwell_last  = (dwell_q == DW'(DWELL - 1));
    last_slot   = dwell_last && (row_idx_q == RW'(ROWS - 1));
    commit      = pending_q && (!en || last_slot);

    dwell_d     = dwell_q;
    row_idx_d   = row_idx_q;
    frame_cnt_d = frame_cnt_q;
    if (!en) begin
      dwell_d   = '0;
      row_idx_d = '0;
    end else if (dwell_last) begin
      dwell_d = '0;
      if (row_idx_q == RW'(ROWS - 1)) begin
        row_idx_d   = '0;
        frame_cnt_d = (frame_cnt_q == FW'(2 * BLINK_FRAMES - 1)) ? '0 : frame_cnt_q + FW'(1);
      end else begin
        row_idx_d = row_idx_q + RW'(1);
      end
    end else begin
      dwell_d = dwell_q + DW'(1);
    end

    // A swap arriving on the commit cycle queues a fresh request.
    pending_d = commit ? swap : (pending_q | swap);
    front_d   = commit ? ~front_q : front_q;
  end

  // Writes always target the bank that is back before this edge's commit.
  always_comb begin
    buf_r_d = buf_r_q;
    buf_g_d = buf_g_q;
    if (wr_en && wr_ok) begin
      buf_r_d[~front_q][wr_row] = wr_r;
      buf_g_d[~front_q][wr_row] = wr_g;
    end
  end

  always_comb begin
    in_blank     = (dwell_q < DW'(BLANK));
    blink_dark   = blink && (frame_cnt_q >= FW'(BLINK_FRAMES));
    row_sel      = ROWS'(1) << row_idx_q;
    row_on       = (ROW_ACTIVE_LOW != 0) ? ~row_sel : row_sel;

    row_d        = ROW_OFF;
    colr_d       = '0;
    colg_d       = '0;
    frame_done_d = en && last_slot;
    if (en && !in_blank) begin
      row_d = row_on;
      if (!blink_dark) begin
        colr_d = buf_r_q[front_q][row_idx_q];
        colg_d = buf_g_q[front_q][row_idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q      <= '0;
      row_idx_q    <= '0;
      frame_cnt_q  <= '0;
      front_q      <= 1'b0;
      pending_q    <= 1'b0;
      row_q        <= ROW_OFF;
      colr_q       <= '0;
      colg_q       <= '0;
      frame_done_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < ROWS; i++) begin
          buf_r_q[b][i] <= '0;
          buf_g_q[b][i] <= '0;
        end
      end
    end else begin
      dwell_q      <= dwell_d;
      row_idx_q    <= row_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      front_q      <= front_d;
      pending_q    <= pending_d;
      row_q        <= row_d;
      colr_q       <= colr_d;
      colg_q       <= colg_d;
      frame_done_q <= frame_done_d;
      buf_r_q      <= buf_r_d;
      buf_g_q      <= buf_g_d;
    end
  end

  assign row        = row_q;
  assign colr       = colr_q;
  assign colg       = colg_q;
  assign swap_busy  = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dz_scan_ctrl.sv
// Directed bench for dz_scan_ctrl: an 8x8 instance (DWELL=4, BLANK=1, BLINK_FRAMES=2)
// plus a 6-row active-high instance for the out-of-range write and no-blank case.
module tb_dz_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, wr_en = 1'b0, swap = 1'b0, blink = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_r = '0, wr_g = '0;
  logic [7:0] row, colr, colg;
  logic       swap_busy, frame_done;

  logic       s_en = 1'b0, s_wr_en = 1'b0, s_swap = 1'b0, s_blink = 1'b0;
  logic [2:0] s_wr_row = '0;
  logic [3:0] s_wr_r = '0, s_wr_g = '0;
  logic [5:0] s_row;
  logic [3:0] s_colr, s_colg;
  logic       s_busy, s_fd;

  int n, n_cmp, n_bad;
  int s, d, r, f, pulses;
  logic        lit, dark, e_fd, e_busy;
  logic [7:0]  e_row, e_r, e_g;
  logic [25:0] got, exp_v;
  logic [5:0]  se_row;
  logic [3:0]  se_r, se_g;
  logic [15:0] s_got, s_exp;

  always #5 clk = ~clk;

  dz_scan_ctrl #(.ROWS(8), .COLS(8), .DWELL(4), .BLANK(1), .BLINK_FRAMES(2), .ROW_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_row(wr_row), .wr_r(wr_r), .wr_g(wr_g),
    .swap(swap), .blink(blink), .row(row), .colr(colr), .colg(colg),
    .swap_busy(swap_busy), .frame_done(frame_done));

  dz_scan_ctrl #(.ROWS(6), .COLS(4), .DWELL(3), .BLANK(0), .BLINK_FRAMES(1), .ROW_ACTIVE_LOW(0)) u_small (
    .clk(clk), .rst_n(rst_n), .en(s_en), .wr_en(s_wr_en), .wr_row(s_wr_row), .wr_r(s_wr_r), .wr_g(s_wr_g),
    .swap(s_swap), .blink(s_blink), .row(s_row), .colr(s_colr), .colg(s_colg),
    .swap_busy(s_busy), .frame_done(s_fd));

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Expected row pins for the 8x8 instance given the scan state s of the previous cycle.
  function automatic logic [7:0] scan_row(int st);
    logic [7:0] one;
    one = 8'h01;
    return ((st % 4) == 0) ? 8'hFF : ~(one << ((st / 4) % 8));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {row, colr, colg, frame_done, swap_busy};
    exp_v = {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("[TB] FAIL reset_main got %h exp %h", got, exp_v); end
    s_got = {s_row, s_colr, s_colg, s_fd, s_busy};
    n_cmp++;
    if (s_got !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_small got %h exp 0000", s_got); end
    @(negedge clk) rst_n = 1'b1;
    step();
    got = {row, colr, colg, frame_done, swap_busy};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("[TB] FAIL idle_en0 got %h exp %h", got, exp_v); end
  endtask

  task automatic test_swap_commit();
    wr_en = 1'b1; wr_row = 3'd3; wr_r = 8'hA5; wr_g = 8'h0F;
    step();
    wr_en = 1'b0;
    swap = 1'b1; en = 1'b1; n = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      swap = 1'b0;
      s = n - 1; d = s % 4; r = (s / 4) % 8;
      lit = (d != 0) && (r == 3) && (s >= 32);
      exp_v = {scan_row(s), lit ? 8'hA5 : 8'h00, lit ? 8'h0F : 8'h00, (n % 32) == 0, n < 32};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL swap_commit n=%0d got %h exp %h", n, got, exp_v); end
    end
  endtask

  task automatic test_free_run();
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      s = n - 1; d = s % 4; r = (s / 4) % 8;
      lit = (d != 0) && (r == 3);
      if (frame_done) pulses++;
      exp_v = {scan_row(s), lit ? 8'hA5 : 8'h00, lit ? 8'h0F : 8'h00, (n % 32) == 0, 1'b0};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL free_run n=%0d got %h exp %h", n, got, exp_v); end
    end
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("[TB] FAIL frame_pulses got %0d exp 2", pulses); end
  endtask

  task automatic test_back_to_back();
    while (n < 192) begin
      wr_en = (n == 128); wr_row = 3'd0; wr_r = 8'hFF; wr_g = 8'h00;
      swap = (n == 144);
      step();
      s = n - 1; d = s % 4; r = (s / 4) % 8;
      if (s < 160) begin
        lit = (d != 0) && (r == 3);
        e_r = lit ? 8'hA5 : 8'h00; e_g = lit ? 8'h0F : 8'h00;
      end else begin
        lit = (d != 0) && (r == 0);
        e_r = lit ? 8'hFF : 8'h00; e_g = 8'h00;
      end
      exp_v = {scan_row(s), e_r, e_g, (n % 32) == 0, (n >= 145) && (n <= 159)};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL mid_swap n=%0d got %h exp %h", n, got, exp_v); end
    end
    wr_en = 1'b0; swap = 1'b0;
  endtask

  task automatic test_blink();
    rst_n = 1'b0; en = 1'b0; blink = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; wr_row = 3'(k); wr_r = 8'hFF; wr_g = 8'hC3;
      step();
    end
    wr_en = 1'b0;
    swap = 1'b1;
    step();
    swap = 1'b0;
    n_cmp++;
    if (swap_busy !== 1'b1) begin n_bad++; $display("[TB] FAIL busy_en0 got %b exp 1", swap_busy); end
    step();
    n_cmp++;
    if (swap_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL commit_en0 got %b exp 0", swap_busy); end
    blink = 1'b1; en = 1'b1; n = 0;
    while (n < 224) begin
      blink = (n < 160);
      step();
      s = n - 1; d = s % 4; f = s / 32;
      dark = (s < 160) && ((f % 4) >= 2);
      lit = (d != 0) && !dark;
      exp_v = {scan_row(s), lit ? 8'hFF : 8'h00, lit ? 8'hC3 : 8'h00, (n % 32) == 0, 1'b0};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL blink n=%0d got %h exp %h", n, got, exp_v); end
    end
  endtask

  task automatic test_enable();
    while (n < 247) begin
      wr_en = (n == 226) || (n == 227);
      wr_row = (n == 226) ? 3'd0 : 3'd2;
      wr_r = (n == 226) ? 8'h81 : 8'h42;
      wr_g = (n == 226) ? 8'h18 : 8'h24;
      swap = (n == 230);
      en = (n < 246);
      step();
      s = n - 1; d = s % 4;
      if (n >= 247) begin
        exp_v = {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
      end else begin
        lit = (d != 0);
        exp_v = {scan_row(s), lit ? 8'hFF : 8'h00, lit ? 8'hC3 : 8'h00, (n % 32) == 0, n >= 231};
      end
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL en_drop n=%0d got %h exp %h", n, got, exp_v); end
    end
    wr_en = 1'b0; swap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      exp_v = {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL en_low n=%0d got %h exp %h", n, got, exp_v); end
    end
    en = 1'b1; n = 0;
    while (n < 64) begin
      blink = (n >= 2);
      step();
      s = n - 1; d = s % 4; r = (s / 4) % 8; f = s / 32;
      dark = (s >= 2) && (f == 0);
      lit = (d != 0) && !dark;
      e_r = !lit ? 8'h00 : (r == 0) ? 8'h81 : (r == 2) ? 8'h42 : 8'h00;
      e_g = !lit ? 8'h00 : (r == 0) ? 8'h18 : (r == 2) ? 8'h24 : 8'h00;
      exp_v = {scan_row(s), e_r, e_g, (n % 32) == 0, 1'b0};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL en_rise n=%0d got %h exp %h", n, got, exp_v); end
    end
  endtask

  task automatic test_reset_mid();
    while (n < 75) begin
      swap = (n == 64); blink = 1'b0;
      step();
      s = n - 1; d = s % 4; r = (s / 4) % 8;
      lit = (d != 0);
      e_r = !lit ? 8'h00 : (r == 0) ? 8'h81 : (r == 2) ? 8'h42 : 8'h00;
      e_g = !lit ? 8'h00 : (r == 0) ? 8'h18 : (r == 2) ? 8'h24 : 8'h00;
      exp_v = {scan_row(s), e_r, e_g, (n % 32) == 0, n >= 65};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL pre_reset n=%0d got %h exp %h", n, got, exp_v); end
    end
    swap = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    got = {row, colr, colg, frame_done, swap_busy};
    exp_v = {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
    n_cmp++;
    if (got !== exp_v) begin n_bad++; $display("[TB] FAIL async_reset got %h exp %h", got, exp_v); end
    en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    s_wr_en = 1'b1; s_wr_row = 3'd7; s_wr_r = 4'hF; s_wr_g = 4'hF;
    step();
    s_wr_row = 3'd6;
    step();
    s_wr_row = 3'd1; s_wr_r = 4'h5; s_wr_g = 4'hA;
    step();
    s_wr_en = 1'b0;
    swap = 1'b1; s_swap = 1'b1;
    step();
    swap = 1'b0; s_swap = 1'b0;
    step();
    n_cmp++;
    if ({swap_busy, s_busy} !== 2'b00) begin n_bad++; $display("[TB] FAIL post_swap_busy got %b exp 00", {swap_busy, s_busy}); end
    en = 1'b1; s_en = 1'b1; n = 0;
    for (int i = 0; i < 36; i++) begin
      step();
      s = n - 1;
      exp_v = {scan_row(s), 8'h00, 8'h00, (n % 32) == 0, 1'b0};
      got = {row, colr, colg, frame_done, swap_busy};
      n_cmp++;
      if (got !== exp_v) begin n_bad++; $display("[TB] FAIL cleared_buf n=%0d got %h exp %h", n, got, exp_v); end
      r = (s / 3) % 6;
      se_row = 6'(1 << r);
      se_r = (r == 1) ? 4'h5 : 4'h0;
      se_g = (r == 1) ? 4'hA : 4'h0;
      s_exp = {se_row, se_r, se_g, (n % 18) == 0, 1'b0};
      s_got = {s_row, s_colr, s_colg, s_fd, s_busy};
      n_cmp++;
      if (s_got !== s_exp) begin n_bad++; $display("[TB] FAIL small_scan n=%0d got %h exp %h", n, s_got, s_exp); end
    end
  endtask

  initial begin
    n = 0; n_cmp = 0; n_bad = 0;
    $display("[TB] dz_scan_ctrl directed tests");
    test_reset();
    test_swap_commit();
    test_free_run();
    test_back_to_back();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
